// File: rtl/par_scaler_bank_pkg.sv
// par_scaler_bank_pkg: stream FSM encoding and sizing helpers shared by the scaler bank.
package par_scaler_bank_pkg;
    typedef enum logic {IDLE, STREAM} state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // The saturation flag sits directly above the reported value.
    function automatic int sat_pos(input int output_bits);
        return output_bits;
    endfunction
endpackage

// File: rtl/par_scaler_bank_if.sv
// par_scaler_bank_if: valid/ready word stream carrying {sat, value} per channel.
interface par_scaler_bank_if #(
    parameter int CH_BITS   = 3,
    parameter int DATA_BITS = 17
);
    logic                 valid;
    logic                 ready;
    logic [CH_BITS-1:0]   chan;
    logic [DATA_BITS-1:0] data;
    logic                 last;

    modport master(output valid, chan, data, last, input ready);
    modport slave(input valid, chan, data, last, output ready);
endinterface

// File: rtl/par_scaler_bank_channel.sv
// par_scaler_bank_channel: one saturating event counter with prescaled snapshot into a shadow register.
module par_scaler_bank_channel #(
    parameter int OUTPUT_BITS  = 16,
    parameter int MAX_PRESCALE = 8,
    parameter int PS_BITS      = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   in_i,
    input  logic                   latch_i,
    input  logic                   load_i,
    input  logic [PS_BITS-1:0]     prescale_i,
    output logic [OUTPUT_BITS:0]   shadow_o
);
    localparam int COUNT_BITS = OUTPUT_BITS + MAX_PRESCALE;

    logic [COUNT_BITS-1:0]  count_q, count_d, shifted;
    logic [PS_BITS-1:0]     shift;
    logic [OUTPUT_BITS:0]   shadow_q, shadow_d;
    logic                   pinned, sat;

    // A pinned counter has lost events, so its snapshot is flagged saturated.
    always_comb begin
        pinned   = &count_q;
        count_d  = latch_i ? COUNT_BITS'(in_i) : count_q + COUNT_BITS'(in_i && !pinned);
        shift    = (prescale_i > PS_BITS'(MAX_PRESCALE)) ? PS_BITS'(MAX_PRESCALE) : prescale_i;
        shifted  = count_q >> shift;
        sat      = pinned || (|(shifted >> OUTPUT_BITS));
        shadow_d = load_i ? {sat, sat ? {OUTPUT_BITS{1'b1}} : shifted[OUTPUT_BITS-1:0]} : shadow_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q  <= '0;
            shadow_q <= '0;
        end else begin
            count_q  <= count_d;
            shadow_q <= shadow_d;
        end
    end

    assign shadow_o = shadow_q;
endmodule

// File: rtl/par_scaler_bank.sv
// par_scaler_bank: multi-channel prescaled scaler; snapshots all channels on latch and streams them out.
module par_scaler_bank
    import par_scaler_bank_pkg::*;
#(
    parameter int NUM_CHANNELS = 8,
    parameter int OUTPUT_BITS  = 16,
    parameter int MAX_PRESCALE = 8,
    localparam int PS_BITS     = clog2(MAX_PRESCALE + 1),
    localparam int CH_BITS     = clog2(NUM_CHANNELS)
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic [NUM_CHANNELS-1:0]         in_i,
    input  logic [NUM_CHANNELS*PS_BITS-1:0] prescale_i,
    input  logic                            latch_i,
    par_scaler_bank_if.master               out_if,
    output logic                            busy_o,
    output logic                            overrun_o
);
    localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(NUM_CHANNELS - 1);

    state_e                         state_q, state_d;
    logic [CH_BITS-1:0]             chan_q, chan_d;
    logic                           overrun_q, accept, handshake, at_last;
    logic [sat_pos(OUTPUT_BITS):0]  shadow [NUM_CHANNELS];

    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
        par_scaler_bank_channel #(
            .OUTPUT_BITS (OUTPUT_BITS),
            .MAX_PRESCALE(MAX_PRESCALE),
            .PS_BITS     (PS_BITS)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_n_i   (rst_n_i),
            .in_i      (in_i[k]),
            .latch_i   (latch_i),
            .load_i    (accept),
            .prescale_i(prescale_i[k*PS_BITS +: PS_BITS]),
            .shadow_o  (shadow[k])
        );
    end

    // A latch coinciding with the final handshake restarts the stream with no idle cycle.
    always_comb begin
        handshake = (state_q == STREAM) && out_if.ready;
        at_last   = chan_q == LAST_CH;
        accept    = latch_i && (state_q == IDLE || (handshake && at_last));
        state_d   = accept ? STREAM : (handshake && at_last) ? IDLE : state_q;
        chan_d    = (accept || (handshake && at_last)) ? '0 : handshake ? chan_q + CH_BITS'(1) : chan_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            chan_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            overrun_q <= latch_i && !accept;
        end
    end

    assign out_if.valid = state_q == STREAM;
    assign out_if.last  = out_if.valid && at_last;
    assign out_if.chan  = chan_q;
    assign out_if.data  = shadow[chan_q];
    assign busy_o       = out_if.valid;
    assign overrun_o    = overrun_q;
endmodule

// File: tb/tb_par_scaler_bank.sv
// tb_par_scaler_bank: directed and randomized checks against a queue-based word-stream model.
module tb_par_scaler_bank;
    localparam int N = 4, OB = 8, MP = 4, PSB = 3, CB = 2;
    localparam int CMAX = (1 << (OB + MP)) - 1;

    logic           clk_i = 1'b0, rst_n_i = 1'b0, latch_i = 1'b0;
    logic [N-1:0]   in_i = '0;
    logic [N*PSB-1:0] prescale_i = '0;
    logic           busy_o, overrun_o;

    par_scaler_bank_if #(.CH_BITS(CB), .DATA_BITS(OB + 1)) out_if ();

    par_scaler_bank #(.NUM_CHANNELS(N), .OUTPUT_BITS(OB), .MAX_PRESCALE(MP)) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .in_i      (in_i),
        .prescale_i(prescale_i),
        .latch_i   (latch_i),
        .out_if    (out_if),
        .busy_o    (busy_o),
        .overrun_o (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    // Words are {last, chan, sat, value}; pend holds the snapshot still owed by the DUT.
    int          cnt [N];
    logic [11:0] pend[$], got[$], exp_w[$];
    int          n_checks = 0, n_fail = 0, vmis = 0;

    function automatic logic [11:0] model_word(int k, int c, int s);
        int   v;
        logic sat;
        v   = c >> (s > MP ? MP : s);
        sat = (v >= (1 << OB)) || (c == CMAX);
        return {k == N - 1, 2'(k), sat, sat ? 8'hFF : 8'(v)};
    endfunction

    task automatic step();
        bit hs, acc, ov;
        hs = pend.size() > 0 && out_if.ready;
        if (hs) begin
            got.push_back({out_if.last, out_if.chan, out_if.data});
            exp_w.push_back(pend.pop_front());
        end
        acc = latch_i && pend.size() == 0;
        if (acc)
            for (int k = 0; k < N; k++)
                pend.push_back(model_word(k, cnt[k], int'(prescale_i[k*PSB +: PSB])));
        ov = latch_i && !acc;
        for (int k = 0; k < N; k++)
            cnt[k] = latch_i ? int'(in_i[k]) : (cnt[k] + int'(in_i[k]) > CMAX ? CMAX : cnt[k] + int'(in_i[k]));
        @(posedge clk_i); #1;
        if (out_if.valid !== (pend.size() > 0) || busy_o !== (pend.size() > 0) || overrun_o !== ov) vmis++;
    endtask

    task automatic pulse(int ch, int n);
        in_i[ch] = 1'b1;
        repeat (n) step();
        in_i[ch] = 1'b0;
    endtask

    task automatic set_ps(int s);
        for (int k = 0; k < N; k++) prescale_i[k*PSB +: PSB] = PSB'(s);
    endtask

    task automatic do_latch();
        latch_i = 1'b1;
        step();
        latch_i = 1'b0;
    endtask

    task automatic drain();
        out_if.ready = 1'b1;
        for (int i = 0; i < 40 && pend.size() > 0; i++) step();
    endtask

    task automatic clear_log();
        got.delete();
        exp_w.delete();
        vmis = 0;
    endtask

    task automatic test_reset();
        out_if.ready = 1'b1;
        rst_n_i = 1'b0;
        pend.delete();
        for (int k = 0; k < N; k++) cnt[k] = 0;
        @(posedge clk_i); #1;
        n_checks++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", out_if.valid); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy_o); end
        n_checks++; if (out_if.last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %0b want 0", out_if.last); end
        n_checks++; if (out_if.chan !== 2'd0) begin n_fail++; $display("FAIL reset_chan: got %0d want 0", out_if.chan); end
        n_checks++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %0b want 0", overrun_o); end
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_basic();
        clear_log();
        set_ps(0);
        pulse(0, 10);
        do_latch();
        drain();
        n_checks++; if (got.size() !== 4) begin n_fail++; $display("FAIL basic_words: got %0d want 4", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            n_checks++; if (got[i] !== exp_w[i]) begin n_fail++; $display("FAIL basic_word%0d: got %h want %h", i, got[i], exp_w[i]); end
        end
        n_checks++; if (got[0] !== {1'b0, 2'd0, 9'd10}) begin n_fail++; $display("FAIL basic_ch0: got %h want %h", got[0], {1'b0, 2'd0, 9'd10}); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %0b want 0", busy_o); end
        n_checks++; if (vmis !== 0) begin n_fail++; $display("FAIL basic_valid_busy_overrun: got %0d bad cycles want 0", vmis); end
    endtask

    task automatic test_prescale();
        clear_log();
        for (int r = 0; r < 3; r++) begin
            set_ps(r == 0 ? 0 : r == 1 ? 2 : 7);
            pulse(1, 300);
            do_latch();
            drain();
        end
        n_checks++; if (got.size() !== 12) begin n_fail++; $display("FAIL prescale_words: got %0d want 12", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            n_checks++; if (got[i] !== exp_w[i]) begin n_fail++; $display("FAIL prescale_word%0d: got %h want %h", i, got[i], exp_w[i]); end
        end
        n_checks++; if (got[1] !== {1'b0, 2'd1, 9'h1FF}) begin n_fail++; $display("FAIL prescale_s0: got %h want %h", got[1], {1'b0, 2'd1, 9'h1FF}); end
        n_checks++; if (got[5] !== {1'b0, 2'd1, 9'd75}) begin n_fail++; $display("FAIL prescale_s2: got %h want %h", got[5], {1'b0, 2'd1, 9'd75}); end
        n_checks++; if (got[9] !== {1'b0, 2'd1, 9'd18}) begin n_fail++; $display("FAIL prescale_s7: got %h want %h", got[9], {1'b0, 2'd1, 9'd18}); end
        n_checks++; if (vmis !== 0) begin n_fail++; $display("FAIL prescale_valid_busy_overrun: got %0d bad cycles want 0", vmis); end
    endtask

    task automatic test_counter_sat();
        clear_log();
        set_ps(4);
        pulse(2, 5000);
        do_latch();
        drain();
        for (int i = 0; i < got.size(); i++) begin
            n_checks++; if (got[i] !== exp_w[i]) begin n_fail++; $display("FAIL sat_word%0d: got %h want %h", i, got[i], exp_w[i]); end
        end
        n_checks++; if (got[2] !== {1'b0, 2'd2, 9'h1FF}) begin n_fail++; $display("FAIL sat_ch2: got %h want %h", got[2], {1'b0, 2'd2, 9'h1FF}); end
    endtask

    task automatic test_coincident();
        clear_log();
        set_ps(0);
        pulse(3, 5);
        in_i[3] = 1'b1;
        do_latch();
        in_i[3] = 1'b0;
        drain();
        do_latch();
        drain();
        for (int i = 0; i < got.size(); i++) begin
            n_checks++; if (got[i] !== exp_w[i]) begin n_fail++; $display("FAIL coinc_word%0d: got %h want %h", i, got[i], exp_w[i]); end
        end
        n_checks++; if (got[3] !== {1'b1, 2'd3, 9'd5}) begin n_fail++; $display("FAIL coinc_first: got %h want %h", got[3], {1'b1, 2'd3, 9'd5}); end
        n_checks++; if (got[7] !== {1'b1, 2'd3, 9'd1}) begin n_fail++; $display("FAIL coinc_carry: got %h want %h", got[7], {1'b1, 2'd3, 9'd1}); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] snap;
        clear_log();
        out_if.ready = 1'b1;
        set_ps(0);
        pulse(1, 7);
        do_latch();
        step();
        snap = {out_if.last, out_if.chan, out_if.data};
        out_if.ready = 1'b0;
        in_i[0] = 1'b1;
        repeat (3) begin
            step();
            n_checks++; if ({out_if.last, out_if.chan, out_if.data} !== snap || out_if.chan !== 2'd1)
                begin n_fail++; $display("FAIL hold_stable: got %h want %h", {out_if.last, out_if.chan, out_if.data}, snap); end
        end
        in_i[0] = 1'b0;
        out_if.ready = 1'b1;
        step();
        out_if.ready = 1'b0;
        do_latch();
        n_checks++; if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL overrun_pulse: got %0b want 1", overrun_o); end
        n_checks++; if (out_if.chan !== 2'd2) begin n_fail++; $display("FAIL overrun_chan: got %0d want 2", out_if.chan); end
        step();
        n_checks++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL overrun_once: got %0b want 0", overrun_o); end
        out_if.ready = 1'b1;
        step();
        do_latch();
        n_checks++; if (out_if.valid !== 1'b1 || out_if.chan !== 2'd0)
            begin n_fail++; $display("FAIL no_bubble: got valid %0b chan %0d want valid 1 chan 0", out_if.valid, out_if.chan); end
        drain();
        n_checks++; if (got.size() !== 8) begin n_fail++; $display("FAIL b2b_words: got %0d want 8", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            n_checks++; if (got[i] !== exp_w[i]) begin n_fail++; $display("FAIL b2b_word%0d: got %h want %h", i, got[i], exp_w[i]); end
        end
        n_checks++; if (got[4] !== 12'h000) begin n_fail++; $display("FAIL b2b_cleared_ch0: got %h want 000", got[4]); end
        n_checks++; if (vmis !== 0) begin n_fail++; $display("FAIL b2b_valid_busy_overrun: got %0d bad cycles want 0", vmis); end
    endtask

    task automatic test_reset_mid();
        clear_log();
        out_if.ready = 1'b1;
        set_ps(0);
        pulse(2, 4);
        do_latch();
        step();
        step();
        n_checks++; if (out_if.chan !== 2'd2) begin n_fail++; $display("FAIL rstmid_chan: got %0d want 2", out_if.chan); end
        #2 rst_n_i = 1'b0;
        #1;
        n_checks++; if (out_if.valid !== 1'b0 || busy_o !== 1'b0)
            begin n_fail++; $display("FAIL rstmid_async: got valid %0b busy %0b want 0 0", out_if.valid, busy_o); end
        pend.delete();
        for (int k = 0; k < N; k++) cnt[k] = 0;
        @(posedge clk_i); #3 rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        clear_log();
        do_latch();
        drain();
        n_checks++; if (got.size() !== 4) begin n_fail++; $display("FAIL rstmid_words: got %0d want 4", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            n_checks++; if (got[i] !== {i == N - 1, 2'(i), 9'd0}) begin n_fail++; $display("FAIL rstmid_word%0d: got %h want %h", i, got[i], {i == N - 1, 2'(i), 9'd0}); end
        end
    endtask

    task automatic test_random();
        int cyc;
        clear_log();
        for (int r = 0; r < 8; r++) begin
            cyc = $urandom_range(20, 500);
            for (int c = 0; c < cyc; c++) begin
                in_i = N'($urandom);
                out_if.ready = $urandom_range(0, 3) != 0;
                latch_i = $urandom_range(0, 40) == 0;
                for (int k = 0; k < N; k++) prescale_i[k*PSB +: PSB] = PSB'($urandom_range(0, 7));
                step();
            end
            latch_i = 1'b0;
            in_i = '0;
        end
        drain();
        n_checks++; if (got.size() == 0) begin n_fail++; $display("FAIL random_no_words: got 0 want >0"); end
        for (int i = 0; i < got.size(); i++) begin
            n_checks++; if (got[i] !== exp_w[i]) begin n_fail++; $display("FAIL random_word%0d: got %h want %h", i, got[i], exp_w[i]); end
        end
        n_checks++; if (vmis !== 0) begin n_fail++; $display("FAIL random_valid_busy_overrun: got %0d bad cycles want 0", vmis); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prescale();
        test_counter_sat();
        test_coincident();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
